nmr_bstrm_sram_arb: RTL and testbench

- Arbiter sharing the single on-chip command SRAM read port between two bitstream sequencers, e.g. a TX pulse sequencer and an RX/gating sequencer.
- Sits between the sequencers' SRAM read requests and the physical SRAM_ADDR/SRAM_CS/SRAM_RD_DAT port.
- Grants round-robin or fixed priority, issues one read at a time, waits the fixed SRAM read latency, and returns the word only to the owning requester.

---
 rtl/nmr_bstrm_sram_arb_if.sv | 38 +++
 rtl/nmr_bstrm_sram_arb.sv | 121 ++++++++++++
 tb/tb_nmr_bstrm_sram_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmr_bstrm_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : nmr_bstrm_sram_arb_if
// Brief    : Requester and SRAM read-port bundle for the bitstream SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface nmr_bstrm_sram_arb_if #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32
);
  logic                       req0;
  logic [SRAM_ADDR_WIDTH-1:0] addr0;
  logic                       gnt0;
  logic                       rdy0;
  logic [SRAM_DAT_WIDTH-1:0]  dat0;
  logic                       req1;
  logic [SRAM_ADDR_WIDTH-1:0] addr1;
  logic                       gnt1;
  logic                       rdy1;
  logic [SRAM_DAT_WIDTH-1:0]  dat1;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic                       sram_cs;
  logic [SRAM_DAT_WIDTH-1:0]  sram_rd_dat;
  logic                       busy;

  // Arbiter side.
  modport slave (
    input  req0, addr0, req1, addr1, sram_rd_dat,
    output gnt0, rdy0, dat0, gnt1, rdy1, dat1, sram_addr, sram_cs, busy
  );

  // Requesters plus SRAM side.
  modport master (
    output req0, addr0, req1, addr1, sram_rd_dat,
    input  gnt0, rdy0, dat0, gnt1, rdy1, dat1, sram_addr, sram_cs, busy
  );
endinterface
`default_nettype wire

// File: rtl/nmr_bstrm_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : nmr_bstrm_sram_arb
// Brief    : Two-requester arbiter for the single command SRAM read port.
// Revision : 1.0 - initial release
// ============================================================================
module nmr_bstrm_sram_arb #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32,
  parameter int RD_LAT          = 2,
  parameter int RR_EN           = 1
) (
  input  logic                clk,
  input  logic                rst,
  nmr_bstrm_sram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_t                     r_state;
  logic                       r_owner;
  logic                       r_ptr;
  logic [3:0]                 r_cnt;
  logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
  logic                       r_sram_cs;
  logic                       r_busy;
  logic                       r_gnt0;
  logic                       r_gnt1;
  logic                       r_rdy0;
  logic                       r_rdy1;
  logic [SRAM_DAT_WIDTH-1:0]  r_dat0;
  logic [SRAM_DAT_WIDTH-1:0]  r_dat1;
  logic                       w_pick;

  // Owner choice for an IDLE cycle; only consulted when some request is up.
  always_comb begin
    w_pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_pick = (RR_EN != 0) ? r_ptr : 1'b0;
    end else if (bus.req1) begin
      w_pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_ptr       <= 1'b0;
      r_cnt       <= 4'd0;
      r_sram_addr <= '0;
      r_sram_cs   <= 1'b0;
      r_busy      <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rdy0      <= 1'b0;
      r_rdy1      <= 1'b0;
      r_dat0      <= '0;
      r_dat1      <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
      r_sram_cs <= 1'b0;
      case (r_state)
        IDLE: begin
          // Strobe and grant are registered so they line up with the ISSUE cycle.
          if (bus.req0 || bus.req1) begin
            r_owner     <= w_pick;
            r_sram_addr <= w_pick ? bus.addr1 : bus.addr0;
            r_sram_cs   <= 1'b1;
            r_gnt0      <= ~w_pick;
            r_gnt1      <= w_pick;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_ptr   <= ~r_owner;
          r_cnt   <= LAT_LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            if (r_owner) begin
              r_dat1 <= bus.sram_rd_dat;
              r_rdy1 <= 1'b1;
            end else begin
              r_dat0 <= bus.sram_rd_dat;
              r_rdy0 <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.rdy0      = r_rdy0;
  assign bus.rdy1      = r_rdy1;
  assign bus.dat0      = r_dat0;
  assign bus.dat1      = r_dat1;
  assign bus.sram_addr = r_sram_addr;
  assign bus.sram_cs   = r_sram_cs;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nmr_bstrm_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmr_bstrm_sram_arb
// Brief    : Directed self-checking bench for nmr_bstrm_sram_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmr_bstrm_sram_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: RD_LAT=2 round-robin, b: RD_LAT=2 fixed priority, c: RD_LAT=1 round-robin
  nmr_bstrm_sram_arb_if #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32)) ifa ();
  nmr_bstrm_sram_arb_if #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32)) ifb ();
  nmr_bstrm_sram_arb_if #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32)) ifc ();

  nmr_bstrm_sram_arb #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32), .RD_LAT(2), .RR_EN(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  nmr_bstrm_sram_arb #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32), .RD_LAT(2), .RR_EN(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  nmr_bstrm_sram_arb #(.SRAM_ADDR_WIDTH(8), .SRAM_DAT_WIDTH(32), .RD_LAT(1), .RR_EN(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'h05:   mem_word = 32'hDEAD_BEEF;
      8'h10:   mem_word = 32'h1010_AAAA;
      8'h20:   mem_word = 32'h2020_BBBB;
      8'h03:   mem_word = 32'h0303_CCCC;
      8'h7F:   mem_word = 32'h7F7F_DDDD;
      default: mem_word = {24'hC0FFEE, a};
    endcase
  endfunction

  // SRAM models: data valid only in the cycle ISSUE+RD_LAT, garbage otherwise.
  logic       a_v1 = 1'b0, a_v2 = 1'b0, b_v1 = 1'b0, b_v2 = 1'b0, c_v1 = 1'b0;
  logic [7:0] a_a1 = '0, a_a2 = '0, b_a1 = '0, b_a2 = '0, c_a1 = '0;

  always @(posedge clk) begin
    a_v1 <= ifa.sram_cs; a_a1 <= ifa.sram_addr; a_v2 <= a_v1; a_a2 <= a_a1;
    b_v1 <= ifb.sram_cs; b_a1 <= ifb.sram_addr; b_v2 <= b_v1; b_a2 <= b_a1;
    c_v1 <= ifc.sram_cs; c_a1 <= ifc.sram_addr;
  end

  assign ifa.sram_rd_dat = a_v2 ? mem_word(a_a2) : 32'hBAD0_BAD0;
  assign ifb.sram_rd_dat = b_v2 ? mem_word(b_a2) : 32'hBAD0_BAD0;
  assign ifc.sram_rd_dat = c_v1 ? mem_word(c_a1) : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.addr0 = '0; ifa.addr1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.addr0 = '0; ifb.addr1 = '0;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.addr0 = '0; ifc.addr1 = '0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Stimulus only: one complete read on dut_a, returns in the RDY cycle.
  task automatic full_read_a(input logic who, input logic [7:0] a);
    if (who) begin ifa.req1 = 1'b1; ifa.addr1 = a; end
    else     begin ifa.req0 = 1'b1; ifa.addr0 = a; end
    tick;
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifa.req0 = 1'b1; ifa.addr0 = 8'h55;
    tick;
    tick;
    checks++;
    if ({ifa.gnt0, ifa.gnt1, ifa.rdy0, ifa.rdy1, ifa.sram_cs, ifa.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {ifa.gnt0, ifa.gnt1, ifa.rdy0, ifa.rdy1, ifa.sram_cs, ifa.busy});
    end
    checks++;
    if ({ifa.sram_addr, ifa.dat0, ifa.dat1} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h dat0=%h dat1=%h expected all 0",
               ifa.sram_addr, ifa.dat0, ifa.dat1);
    end
    ifa.req0 = 1'b0;
    rst = 1'b0;
    tick;
    checks++;
    if ({ifa.sram_cs, ifa.busy, ifa.gnt0, ifc.sram_cs, ifc.busy} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 00000",
               {ifa.sram_cs, ifa.busy, ifa.gnt0, ifc.sram_cs, ifc.busy});
    end
  endtask

  task automatic test_single_read;
    do_reset;
    ifa.req0 = 1'b1; ifa.addr0 = 8'h05;
    tick;
    checks++;
    if ({ifa.gnt0, ifa.gnt1, ifa.sram_cs, ifa.busy} !== 4'b1011 || ifa.sram_addr !== 8'h05) begin
      errors++;
      $display("FAIL single_issue: got gnt0,gnt1,cs,busy=%b addr=%h expected 1011 addr=05",
               {ifa.gnt0, ifa.gnt1, ifa.sram_cs, ifa.busy}, ifa.sram_addr);
    end
    ifa.req0 = 1'b0;
    tick;
    checks++;
    if ({ifa.gnt0, ifa.sram_cs, ifa.rdy0, ifa.busy} !== 4'b0001 || ifa.sram_addr !== 8'h05) begin
      errors++;
      $display("FAIL single_wait: got gnt0,cs,rdy0,busy=%b addr=%h expected 0001 addr=05",
               {ifa.gnt0, ifa.sram_cs, ifa.rdy0, ifa.busy}, ifa.sram_addr);
    end
    tick;
    checks++;
    if (ifa.rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_early_rdy: got rdy0=%b expected 0", ifa.rdy0);
    end
    tick;
    checks++;
    if ({ifa.rdy0, ifa.rdy1, ifa.busy} !== 3'b100 || ifa.dat0 !== 32'hDEAD_BEEF || ifa.dat1 !== 32'h0) begin
      errors++;
      $display("FAIL single_rdy: got rdy0,rdy1,busy=%b dat0=%h dat1=%h expected 100 DEADBEEF 00000000",
               {ifa.rdy0, ifa.rdy1, ifa.busy}, ifa.dat0, ifa.dat1);
    end
    tick;
    checks++;
    if (ifa.rdy0 !== 1'b0 || ifa.dat0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_hold: got rdy0=%b dat0=%h expected 0 DEADBEEF", ifa.rdy0, ifa.dat0);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    do_reset;
    ifa.req0 = 1'b1; ifa.addr0 = 8'h10;
    ifa.req1 = 1'b1; ifa.addr1 = 8'h20;
    for (int k = 1; k <= 16; k++) begin
      tick;
      exp = {(k == 1 || k == 9), (k == 5 || k == 13), (k == 4 || k == 12),
             (k == 8 || k == 16), (k == 1 || k == 5 || k == 9 || k == 13)};
      checks++;
      if ({ifa.gnt0, ifa.gnt1, ifa.rdy0, ifa.rdy1, ifa.sram_cs} !== exp) begin
        errors++;
        $display("FAIL rr_seq cycle %0d: got gnt0,gnt1,rdy0,rdy1,cs=%b expected %b",
                 k, {ifa.gnt0, ifa.gnt1, ifa.rdy0, ifa.rdy1, ifa.sram_cs}, exp);
      end
      if (k == 1 || k == 5 || k == 9 || k == 13) begin
        checks++;
        if (ifa.sram_addr !== ((k == 1 || k == 9) ? 8'h10 : 8'h20)) begin
          errors++;
          $display("FAIL rr_addr cycle %0d: got %h expected %h",
                   k, ifa.sram_addr, (k == 1 || k == 9) ? 8'h10 : 8'h20);
        end
      end
      if (k == 4 || k == 12) begin
        checks++;
        if (ifa.dat0 !== 32'h1010_AAAA) begin
          errors++;
          $display("FAIL rr_dat0 cycle %0d: got %h expected 1010AAAA", k, ifa.dat0);
        end
      end
      if (k == 8 || k == 16) begin
        checks++;
        if (ifa.dat1 !== 32'h2020_BBBB) begin
          errors++;
          $display("FAIL rr_dat1 cycle %0d: got %h expected 2020BBBB", k, ifa.dat1);
        end
      end
      if (k == 13) begin
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
      end
    end
  endtask

  task automatic test_fixed_priority;
    logic [3:0] exp;
    do_reset;
    ifb.req0 = 1'b1; ifb.addr0 = 8'h10;
    ifb.req1 = 1'b1; ifb.addr1 = 8'h20;
    for (int k = 1; k <= 16; k++) begin
      tick;
      exp = {(k == 1 || k == 5 || k == 9), (k == 13), (k == 4 || k == 8 || k == 12), (k == 16)};
      checks++;
      if ({ifb.gnt0, ifb.gnt1, ifb.rdy0, ifb.rdy1} !== exp) begin
        errors++;
        $display("FAIL fixed_seq cycle %0d: got gnt0,gnt1,rdy0,rdy1=%b expected %b",
                 k, {ifb.gnt0, ifb.gnt1, ifb.rdy0, ifb.rdy1}, exp);
      end
      if (k == 9)  ifb.req0 = 1'b0;
      if (k == 13) ifb.req1 = 1'b0;
    end
    checks++;
    if (ifb.dat1 !== 32'h2020_BBBB || ifb.dat0 !== 32'h1010_AAAA) begin
      errors++;
      $display("FAIL fixed_dat: got dat0=%h dat1=%h expected 1010AAAA 2020BBBB", ifb.dat0, ifb.dat1);
    end
  endtask

  task automatic test_reset_abort;
    do_reset;
    full_read_a(1'b1, 8'h20);
    full_read_a(1'b0, 8'h10);
    checks++;
    if (ifa.dat1 !== 32'h2020_BBBB || ifa.dat0 !== 32'h1010_AAAA) begin
      errors++;
      $display("FAIL abort_pre: got dat0=%h dat1=%h expected 1010AAAA 2020BBBB", ifa.dat0, ifa.dat1);
    end
    ifa.req1 = 1'b1; ifa.addr1 = 8'h20;
    tick;
    ifa.req1 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({ifa.sram_cs, ifa.busy, ifa.rdy1} !== 3'b000 || ifa.dat1 !== 32'h0 || ifa.dat0 !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: got cs,busy,rdy1=%b dat0=%h dat1=%h expected 000 0 0",
               {ifa.sram_cs, ifa.busy, ifa.rdy1}, ifa.dat0, ifa.dat1);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({ifa.rdy1, ifa.rdy0, ifa.sram_cs} !== 3'b000) begin
        errors++;
        $display("FAIL abort_no_rdy cycle %0d: got rdy1,rdy0,cs=%b expected 000",
                 k, {ifa.rdy1, ifa.rdy0, ifa.sram_cs});
      end
    end
    ifa.req0 = 1'b1; ifa.addr0 = 8'h10;
    ifa.req1 = 1'b1; ifa.addr1 = 8'h20;
    tick;
    checks++;
    if ({ifa.gnt0, ifa.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL abort_regrant: got gnt0,gnt1=%b expected 10", {ifa.gnt0, ifa.gnt1});
    end
    // Pointer now names requester 1; a reset mid-WAIT must send it back to 0.
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ifa.req0 = 1'b1;
    ifa.req1 = 1'b1;
    tick;
    checks++;
    if ({ifa.gnt0, ifa.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL ptr_reset: got gnt0,gnt1=%b expected 10", {ifa.gnt0, ifa.gnt1});
    end
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
  endtask

  task automatic test_lat1_addr_change;
    do_reset;
    ifc.req0 = 1'b1; ifc.addr0 = 8'h03;
    tick;
    checks++;
    if ({ifc.gnt0, ifc.sram_cs} !== 2'b11 || ifc.sram_addr !== 8'h03) begin
      errors++;
      $display("FAIL lat1_issue: got gnt0,cs=%b addr=%h expected 11 addr=03",
               {ifc.gnt0, ifc.sram_cs}, ifc.sram_addr);
    end
    ifc.req0 = 1'b0;
    ifc.addr0 = 8'h7F;
    tick;
    checks++;
    if ({ifc.sram_cs, ifc.rdy0, ifc.busy} !== 3'b001 || ifc.sram_addr !== 8'h03) begin
      errors++;
      $display("FAIL lat1_wait: got cs,rdy0,busy=%b addr=%h expected 001 addr=03",
               {ifc.sram_cs, ifc.rdy0, ifc.busy}, ifc.sram_addr);
    end
    tick;
    checks++;
    if ({ifc.rdy0, ifc.busy} !== 2'b10 || ifc.dat0 !== 32'h0303_CCCC) begin
      errors++;
      $display("FAIL lat1_rdy: got rdy0,busy=%b dat0=%h expected 10 0303CCCC",
               {ifc.rdy0, ifc.busy}, ifc.dat0);
    end
  endtask

  task automatic test_ignored_req;
    int cs_count;
    cs_count = 0;
    do_reset;
    ifa.req0 = 1'b1; ifa.addr0 = 8'h10;
    tick;
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b1; ifa.addr1 = 8'h20;
    tick;
    tick;
    ifa.req1 = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      tick;
      if (ifa.sram_cs) cs_count++;
      checks++;
      if ({ifa.gnt1, ifa.rdy1, ifa.rdy0} !== {2'b00, k == 4}) begin
        errors++;
        $display("FAIL ignored_req cycle %0d: got gnt1,rdy1,rdy0=%b expected %b",
                 k, {ifa.gnt1, ifa.rdy1, ifa.rdy0}, {2'b00, k == 4});
      end
    end
    checks++;
    if (cs_count != 0) begin
      errors++;
      $display("FAIL ignored_cs: got %0d strobes expected 0", cs_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.addr0 = '0; ifa.addr1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.addr0 = '0; ifb.addr1 = '0;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.addr0 = '0; ifc.addr1 = '0;
    test_reset;
    test_single_read;
    test_back_to_back;
    test_fixed_priority;
    test_reset_abort;
    test_lat1_addr_change;
    test_ignored_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
